predicate_tracker: RTL and testbench

Per-entry predicate state tracker for a reservation station: holds the predicate configuration (`_t`/`_f`) of up to NUM_ENTRIES mapped instructions and latches predicate operands arriving on NUM_PORTS parallel operand ports. It gives each entry a registered fire-enable, and queues predicate-failed entries as squash notifications through a valid/ready handshake. It is the multi-entry, multi-port, stateful successor to the single-operand combinational predicate check, and adds null-token propagation and block flush.

---
 rtl/predicate_tracker_pkg.sv | 18 +
 rtl/predicate_tracker_entry.sv | 58 +++++
 rtl/predicate_tracker.sv | 127 ++++++++++++
 tb/tb_predicate_tracker.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/predicate_tracker_pkg.sv
// Shared types for the reservation-station predicate tracker.
// Entry lifecycle: EMPTY -> WAIT/READY on cfg, WAIT -> READY/SQUASH on operand arrival.
package predicate_tracker_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    SQUASH = 2'd3
  } pred_state_t;

  // A null token always fails the predicate; otherwise the operand must equal the polarity.
  function automatic pred_state_t pred_resolve(input logic pol, input logic is_null,
                                               input logic bit0);
    pred_resolve = (!is_null && (bit0 == pol)) ? READY : SQUASH;
  endfunction

endpackage

// File: rtl/predicate_tracker_entry.sv
// One tracked reservation-station entry: state register, stored polarity and
// its next-state rule; the current state is exposed for error checking.
module predicate_tracker_entry
  import predicate_tracker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        cfg_hit,
  input  logic        cfg_pred_en,
  input  logic        cfg_pred_true,
  input  logic        op_hit,
  input  logic        op_null,
  input  logic        op_bit,
  input  logic        issue_hit,
  input  logic        squash_acc,
  output pred_state_t state,
  output logic        ready,
  output logic        squash_pend
);

  pred_state_t state_q, state_d;
  logic        pol_q, pol_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pol_q   <= pol_d;
    end
  end

  // Priority: flush > cfg > operand arrival > issue / squash accept.
  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (cfg_hit) begin
      state_d = cfg_pred_en ? WAIT : READY;
      pol_d   = cfg_pred_true;
    end else if (op_hit && (state_q == WAIT)) begin
      state_d = pred_resolve(pol_q, op_null, op_bit);
    end else if ((issue_hit && (state_q == READY)) ||
                 (squash_acc && (state_q == SQUASH))) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    state       = state_q;
    ready       = (state_q == READY);
    squash_pend = (state_q == SQUASH);
  end

endmodule

// File: rtl/predicate_tracker.sv
// Multi-entry predicate tracker: operand port arbitration, per-entry state,
// lowest-index squash queue (valid/ready) and registered dup_err pulse.
module predicate_tracker
  import predicate_tracker_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_PORTS   = 2,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        cfg_valid,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic                        cfg_pred_en,
  input  logic                        cfg_pred_true,
  input  logic [NUM_PORTS-1:0]        op_valid,
  input  logic [NUM_PORTS*IDX_W-1:0]  op_idx,
  input  logic [NUM_PORTS*DATA_W-1:0] op_data,
  input  logic [NUM_PORTS-1:0]        op_null,
  input  logic                        issue_done_valid,
  input  logic [IDX_W-1:0]            issue_done_idx,
  output logic [NUM_ENTRIES-1:0]      pred_ok,
  output logic                        squash_valid,
  output logic [IDX_W-1:0]            squash_idx,
  input  logic                        squash_ready,
  output logic                        dup_err
);

  // Squash handshake: squash_idx is offered while squash_valid=1 and retires
  // exactly on the cycle where squash_valid & squash_ready are both high.

  pred_state_t              entry_state [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   squash_pend;
  logic [NUM_PORTS-1:0]     port_win;
  logic [NUM_ENTRIES-1:0]   cfg_hit, op_hit, op_null_e, op_bit_e, issue_hit, squash_acc;
  logic                     err_d;
  logic                     unused_op_data;

  assign unused_op_data = ^op_data;

  // The lowest port wins when several ports target one entry in a cycle.
  always_comb begin
    port_win = op_valid;
    for (int p = 1; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (op_valid[q] && (op_idx[q*IDX_W +: IDX_W] == op_idx[p*IDX_W +: IDX_W]))
          port_win[p] = 1'b0;
      end
    end
  end

  always_comb begin
    cfg_hit    = '0;
    op_hit     = '0;
    op_null_e  = '0;
    op_bit_e   = '0;
    issue_hit  = '0;
    squash_acc = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      cfg_hit[e]    = cfg_valid && (cfg_idx == IDX_W'(e));
      issue_hit[e]  = issue_done_valid && (issue_done_idx == IDX_W'(e));
      squash_acc[e] = squash_valid && squash_ready && (squash_idx == IDX_W'(e));
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_win[p] && (op_idx[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
          op_hit[e]    = 1'b1;
          op_null_e[e] = op_null[p];
          op_bit_e[e]  = op_data[p*DATA_W];
        end
      end
    end
  end

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
    predicate_tracker_entry u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .cfg_hit       (cfg_hit[e]),
      .cfg_pred_en   (cfg_pred_en),
      .cfg_pred_true (cfg_pred_true),
      .op_hit        (op_hit[e]),
      .op_null       (op_null_e[e]),
      .op_bit        (op_bit_e[e]),
      .issue_hit     (issue_hit[e]),
      .squash_acc    (squash_acc[e]),
      .state         (entry_state[e]),
      .ready         (pred_ok[e]),
      .squash_pend   (squash_pend[e])
    );
  end

  always_comb begin
    squash_valid = 1'b0;
    squash_idx   = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (squash_pend[e]) begin
        squash_valid = 1'b1;
        squash_idx   = IDX_W'(e);
      end
    end
  end

  // An arrival losing arbitration, hitting a non-WAIT entry, or colliding with
  // a same-cycle cfg is an error, as is issuing an entry that is not READY.
  always_comb begin
    err_d = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (op_valid[p]) begin
        if (!port_win[p])
          err_d = 1'b1;
        else if ((entry_state[op_idx[p*IDX_W +: IDX_W]] != WAIT) ||
                 (cfg_valid && (cfg_idx == op_idx[p*IDX_W +: IDX_W])))
          err_d = 1'b1;
      end
    end
    if (issue_done_valid && (entry_state[issue_done_idx] != READY))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_err <= 1'b0;
    else        dup_err <= err_d && !flush;
  end

endmodule

// File: tb/tb_predicate_tracker.sv
// Directed scenarios plus randomized traffic for predicate_tracker, checked
// against an entry-level behavioural model held in this bench.
module tb_predicate_tracker;
  localparam int NE = 8;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int M_EMPTY = 0, M_WAIT = 1, M_READY = 2, M_SQUASH = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic            cfg_pred_en = 1'b0;
  logic            cfg_pred_true = 1'b0;
  logic [NP-1:0]   op_valid = '0;
  logic [NP*IW-1:0] op_idx = '0;
  logic [NP*DW-1:0] op_data = '0;
  logic [NP-1:0]   op_null = '0;
  logic            issue_done_valid = 1'b0;
  logic [IW-1:0]   issue_done_idx = '0;
  logic [NE-1:0]   pred_ok;
  logic            squash_valid;
  logic [IW-1:0]   squash_idx;
  logic            squash_ready = 1'b0;
  logic            dup_err;

  int m_st [NE];
  bit m_pol [NE];
  bit m_err;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  predicate_tracker #(.NUM_ENTRIES(NE), .NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_pred_en(cfg_pred_en),
    .cfg_pred_true(cfg_pred_true),
    .op_valid(op_valid), .op_idx(op_idx), .op_data(op_data), .op_null(op_null),
    .issue_done_valid(issue_done_valid), .issue_done_idx(issue_done_idx),
    .pred_ok(pred_ok), .squash_valid(squash_valid), .squash_idx(squash_idx),
    .squash_ready(squash_ready), .dup_err(dup_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [NE-1:0] m_ok();
    logic [NE-1:0] v = '0;
    for (int e = 0; e < NE; e++) v[e] = (m_st[e] == M_READY);
    return v;
  endfunction

  function automatic int m_sq();
    for (int e = 0; e < NE; e++) if (m_st[e] == M_SQUASH) return e;
    return -1;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin
      m_st[e] = M_EMPTY;
      m_pol[e] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Applies the rules for one cycle using the currently driven inputs.
  task automatic model_update();
    int nxt [NE];
    bit seen [NE];
    int i;
    int sq;
    for (int e = 0; e < NE; e++) begin
      nxt[e] = m_st[e];
      seen[e] = 1'b0;
    end
    sq = m_sq();
    m_err = 1'b0;
    if (flush) begin
      for (int e = 0; e < NE; e++) nxt[e] = M_EMPTY;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (op_valid[p]) begin
          i = int'(op_idx[p*IW +: IW]);
          if (seen[i]) m_err = 1'b1;
          else begin
            seen[i] = 1'b1;
            if (m_st[i] != M_WAIT || (cfg_valid && int'(cfg_idx) == i)) m_err = 1'b1;
            else nxt[i] = (op_null[p] || (op_data[p*DW] != m_pol[i])) ? M_SQUASH : M_READY;
          end
        end
      end
      if (issue_done_valid) begin
        i = int'(issue_done_idx);
        if (m_st[i] != M_READY) m_err = 1'b1;
        else nxt[i] = M_EMPTY;
      end
      if (sq >= 0 && squash_ready) nxt[sq] = M_EMPTY;
      if (cfg_valid) begin
        nxt[cfg_idx] = cfg_pred_en ? M_WAIT : M_READY;
        m_pol[cfg_idx] = cfg_pred_true;
      end
    end
    for (int e = 0; e < NE; e++) m_st[e] = nxt[e];
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    flush = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_pred_en = 1'b0; cfg_pred_true = 1'b0;
    op_valid = '0; op_idx = '0; op_data = '0; op_null = '0;
    issue_done_valid = 1'b0; issue_done_idx = '0; squash_ready = 1'b0;
  endtask

  task automatic set_cfg(input int idx, input logic en, input logic pol);
    cfg_valid = 1'b1; cfg_idx = IW'(idx); cfg_pred_en = en; cfg_pred_true = pol;
  endtask

  task automatic set_op(input int p, input int idx, input logic [DW-1:0] d, input logic nul);
    op_valid[p] = 1'b1;
    op_idx[p*IW +: IW] = IW'(idx);
    op_data[p*DW +: DW] = d;
    op_null[p] = nul;
  endtask

  task automatic set_issue(input int idx);
    issue_done_valid = 1'b1; issue_done_idx = IW'(idx);
  endtask

  // Model and DUT advance on the same edge; outputs settle 1ns later.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pred_ok !== 8'h00 || squash_valid !== 1'b0 || squash_idx !== 3'd0 || dup_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pred_ok=%b sv=%b sidx=%0d dup=%b, need all zero",
               pred_ok, squash_valid, squash_idx, dup_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fire_issue();
    set_cfg(3, 1'b1, 1'b1); step();
    vectors++;
    if (pred_ok !== 8'h00) begin
      miscompares++; $display("FAIL fire_wait: pred_ok=%b need %b", pred_ok, 8'h00);
    end
    set_op(0, 3, 32'h1, 1'b0); step();
    vectors++;
    if (pred_ok !== 8'b0000_1000 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL fire_ready: pred_ok=%b dup=%b need 00001000/0", pred_ok, dup_err);
    end
    set_issue(3); step();
    vectors++;
    if (pred_ok !== 8'h00 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL fire_issue: pred_ok=%b dup=%b need 0/0", pred_ok, dup_err);
    end
    set_issue(3); step();
    vectors++;
    if (dup_err !== 1'b1) begin
      miscompares++; $display("FAIL issue_empty_err: dup=%b need 1", dup_err);
    end
  endtask

  task automatic test_squash_hold();
    set_cfg(5, 1'b1, 1'b0); step();
    set_op(1, 5, 32'hFFFF_FFFF, 1'b0); step();
    vectors++;
    if (squash_valid !== 1'b1 || squash_idx !== 3'd5 || pred_ok !== 8'h00) begin
      miscompares++; $display("FAIL squash_f: sv=%b sidx=%0d ok=%b need 1/5/0", squash_valid, squash_idx, pred_ok);
    end
    for (int k = 0; k < 3; k++) begin
      squash_ready = 1'b0; step();
      vectors++;
      if (squash_valid !== 1'b1 || squash_idx !== 3'd5) begin
        miscompares++; $display("FAIL squash_hold%0d: sv=%b sidx=%0d need 1/5", k, squash_valid, squash_idx);
      end
    end
    squash_ready = 1'b1; step();
    vectors++;
    if (squash_valid !== 1'b0) begin
      miscompares++; $display("FAIL squash_accept: sv=%b need 0", squash_valid);
    end
  endtask

  task automatic test_null_drain();
    set_cfg(1, 1'b1, 1'b1); step();
    set_cfg(6, 1'b1, 1'b1); step();
    set_op(0, 1, 32'h1, 1'b1);
    set_op(1, 6, 32'h0, 1'b0);
    step();
    vectors++;
    if (squash_valid !== 1'b1 || squash_idx !== 3'd1 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL drain_first: sv=%b sidx=%0d dup=%b need 1/1/0", squash_valid, squash_idx, dup_err);
    end
    squash_ready = 1'b1; step();
    vectors++;
    if (squash_valid !== 1'b1 || squash_idx !== 3'd6) begin
      miscompares++; $display("FAIL drain_second: sv=%b sidx=%0d need 1/6", squash_valid, squash_idx);
    end
    squash_ready = 1'b1; step();
    vectors++;
    if (squash_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_empty: sv=%b need 0", squash_valid);
    end
  endtask

  task automatic test_port_conflict();
    set_cfg(2, 1'b1, 1'b1); step();
    set_op(0, 2, 32'h1, 1'b0);
    set_op(1, 2, 32'h0, 1'b0);
    step();
    vectors++;
    if (pred_ok !== 8'b0000_0100 || squash_valid !== 1'b0 || dup_err !== 1'b1) begin
      miscompares++; $display("FAIL port_conflict: ok=%b sv=%b dup=%b need 00000100/0/1", pred_ok, squash_valid, dup_err);
    end
    step();
    vectors++;
    if (dup_err !== 1'b0) begin
      miscompares++; $display("FAIL dup_pulse_len: dup=%b need 0", dup_err);
    end
    set_op(1, 2, 32'h0, 1'b0); step();
    vectors++;
    if (pred_ok !== 8'b0000_0100 || squash_valid !== 1'b0 || dup_err !== 1'b1) begin
      miscompares++; $display("FAIL late_arrival: ok=%b sv=%b dup=%b need 00000100/0/1", pred_ok, squash_valid, dup_err);
    end
    set_cfg(2, 1'b1, 1'b1);
    set_op(0, 2, 32'h1, 1'b0);
    step();
    vectors++;
    if (pred_ok !== 8'h00 || dup_err !== 1'b1) begin
      miscompares++; $display("FAIL cfg_over_op: ok=%b dup=%b need 0/1", pred_ok, dup_err);
    end
  endtask

  task automatic test_flush();
    set_cfg(0, 1'b0, 1'b0); step();
    vectors++;
    if (pred_ok[0] !== 1'b1) begin
      miscompares++; $display("FAIL unpredicated: ok[0]=%b need 1", pred_ok[0]);
    end
    set_cfg(4, 1'b1, 1'b1); step();
    set_op(0, 4, 32'h1, 1'b1); step();
    vectors++;
    if (squash_valid !== 1'b1 || squash_idx !== 3'd4) begin
      miscompares++; $display("FAIL pre_flush_sq: sv=%b sidx=%0d need 1/4", squash_valid, squash_idx);
    end
    flush = 1'b1;
    set_op(1, 7, 32'h0, 1'b0);
    set_issue(5);
    step();
    vectors++;
    if (pred_ok !== 8'h00 || squash_valid !== 1'b0 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL flush: ok=%b sv=%b dup=%b need 0/0/0", pred_ok, squash_valid, dup_err);
    end
  endtask

  task automatic test_random();
    int sq;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0)
        set_cfg($urandom_range(0, NE-1), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 1) == 1)
          set_op(p, $urandom_range(0, NE-1), $urandom, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) set_issue($urandom_range(0, NE-1));
      squash_ready = 1'($urandom_range(0, 1));
      step();
      sq = m_sq();
      vectors++;
      if (pred_ok !== m_ok()) begin
        miscompares++; $display("FAIL rnd_ok c%0d: got %b need %b", c, pred_ok, m_ok());
      end
      vectors++;
      if (squash_valid !== (sq >= 0)) begin
        miscompares++; $display("FAIL rnd_sv c%0d: got %b need %b", c, squash_valid, sq >= 0);
      end
      if (sq >= 0) begin
        vectors++;
        if (int'(squash_idx) != sq) begin
          miscompares++; $display("FAIL rnd_sidx c%0d: got %0d need %0d", c, squash_idx, sq);
        end
      end
      vectors++;
      if (dup_err !== m_err) begin
        miscompares++; $display("FAIL rnd_dup c%0d: got %b need %b", c, dup_err, m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b1; step();
    set_cfg(7, 1'b1, 1'b1); step();
    set_op(0, 7, 32'h0, 1'b0); step();
    vectors++;
    if (squash_valid !== 1'b1 || squash_idx !== 3'd7) begin
      miscompares++; $display("FAIL arst_setup: sv=%b sidx=%0d need 1/7", squash_valid, squash_idx);
    end
    set_cfg(2, 1'b0, 1'b0); step();
    set_op(1, 3, 32'h1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pred_ok !== 8'h00 || squash_valid !== 1'b0 || squash_idx !== 3'd0 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL arst_async: ok=%b sv=%b sidx=%0d dup=%b need all zero",
                              pred_ok, squash_valid, squash_idx, dup_err);
    end
    clear_inputs();
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    vectors++;
    if (pred_ok !== 8'h00 || squash_valid !== 1'b0 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL arst_release: ok=%b sv=%b dup=%b need 0/0/0", pred_ok, squash_valid, dup_err);
    end
  endtask

  initial begin
    test_reset();
    test_fire_issue();
    test_squash_hold();
    test_null_drain();
    test_port_conflict();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
